cub_root_seq: RTL
=================

// Module: cub_root_seq
// PURPOSE
//  Parametrised sequential integer cube root: y_bo = floor(cbrt(x_bi)) for an XW-bit unsigned operand.
//  Successor of the fixed 9-bit cube-root unit: generic width and an internal shift-add multiplier
//  (no external mult instance). Adds busy/ready handshake, restart from DONE and an optional remainder.
//  Sits beside the ALU as a multi-cycle functional unit driven by the core's start/ready protocol.
// PARAMETERS
//  XW  24           operand width in bits (>=3)
//  YW  (XW+2)/3     localparam; result width = number of 3-bit digit groups
// PORTS
//  clk_i    in   1    clock, all state on rising edge
//  rst_i    in   1    reset, asynchronous, active-high
//  start_i  in   1    request; sampled only in IDLE or DONE
//  x_bi     in   XW   operand; captured on accepted start, ignored otherwise
//  busy_o   out  1    high while a computation is in progress
//  ready_o  out  1    high in DONE; y_bo (and rem_bo) valid
//  y_bo     out  YW   result, held until the next completion
//  rem_bo   out  XW   x_bi - y_bo^3 (only with CUB_REM_EN)
// BEHAVIOUR
//  Reset (async, rst_i=1): state=IDLE, busy_o=0, ready_o=0, y_bo=0, rem_bo=0, internal x/y/s/b cleared.
//  Reset mid-operation aborts immediately; no partial result is exposed.
//  States: IDLE -> SHIFT -> MUL -> CMP -> (SHIFT | DONE); DONE -> SHIFT on start_i, else stays in DONE.
//  IDLE/DONE + start_i: x<=x_bi, y<=0, s<=3*(YW-1), ready_o<=0, busy_o<=1, go to SHIFT.
//  SHIFT (1 cyc): y<=y<<1; load multiplier operands a=y<<1, m=(y<<1)|1 (= y+1 after doubling, even y).
//  MUL (exactly YW cyc): shift-add p=a*m, one multiplier bit per cycle, LSB first; p is 2*YW bits.
//  CMP (1 cyc): b=((p<<1)+p+1)<<s computed at 3*YW+2 bits, no truncation;
//   if x>=b: x<=x-b, y<=y|1. If s==0 -> DONE, else s<=s-3 -> SHIFT.
//  DONE entry: y_bo<=y, ready_o<=1, busy_o<=0 (same edge).
//  Latency: YW*(YW+2) cycles in SHIFT/MUL/CMP; ready_o rises on edge YW*(YW+2)+1 after the start edge
//   (XW=24: 81; XW=9: 16).
//  start_i while busy_o=1 is ignored; x_bi changes while busy do not affect the result.
//  start_i in DONE starts a new operation on the same edge; ready_o falls on that edge.
//  XW not a multiple of 3: x zero-extended to 3*YW bits internally; result still exact.
//  x=0 and x=2^XW-1 need no special casing; x never underflows (subtract only when x>=b).
// CONFIGURATION
//  CUB_REM_EN defined: port rem_bo present, loaded with the final x on DONE entry (= x_bi - y^3), reset 0.
//  CUB_REM_EN undefined: rem_bo port and its register absent; all other behaviour and latency identical.
// TESTING
//  XW=24, x=0 -> y_bo=0, rem_bo=0, ready_o on edge 81, busy_o high edges 1..80.
//  XW=24, x=8 / 27 / 26 -> y_bo=2 / 3 / 2, rem_bo=0 / 0 / 18.
//  XW=24, x=16777215 -> y_bo=255, rem_bo=195840; XW=9, x=511 -> y_bo=7, rem_bo=168, ready edge 16.
//  XW=24, start x=1000, pulse start_i with x=8 at edge 40 -> ignored, y_bo=10 at edge 81.
//  From DONE, start x=125 with start_i held -> ready_o drops, new y_bo=5 at edge 81 of new op.
//  rst_i=1 at edge 30 of x=1000 -> busy_o=0, ready_o=0, y_bo=0 immediately; next start x=64 -> 4.
//  Random sweep (XW=9 exhaustive, XW=24 10k random) vs model floor(cbrt(x)) and x-y^3.

Source files
------------

// File: rtl/cub_root_seq.sv
// cub_root_seq -- sequential integer cube root, y_bo = floor(cbrt(x_bi)).
// Digit-recurrence over 3-bit groups of the operand, MSB group first. Each
// result bit costs one SHIFT cycle, YW shift-add multiply cycles and one
// compare/subtract cycle; a final commit cycle publishes the result.
// Optional feature macro: CUB_REM_EN adds the rem_bo port (x_bi - y_bo^3).
module cub_root_seq #(
   parameter  int XW = 24,
   localparam int YW = (XW + 2) / 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [XW-1:0] x_bi,
   output logic          busy_o,
   output logic          ready_o,
   output logic [YW-1:0] y_bo
`ifdef CUB_REM_EN
   ,
   output logic [XW-1:0] rem_bo
`endif
);

   // Internal widths: operand padded to whole 3-bit groups, product of two
   // YW-bit factors, and the trial subtrahend which needs two guard bits so
   // (3p+1)<<s never wraps.
   localparam int XI = 3 * YW;
   localparam int PW = 2 * YW;
   localparam int BW = 3 * YW + 2;
   localparam int SW = $clog2(3 * YW);
   localparam int CW = $clog2(YW + 1);
   localparam logic [SW-1:0] S_INIT = SW'(3 * (YW - 1));
   localparam logic [CW-1:0] MUL_LAST = CW'(YW - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_MUL   = 3'd2,
      ST_CMP   = 3'd3,
      ST_FIN   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t          state_reg;
   logic [XI-1:0]   x_reg;     // running remainder
   logic [YW-1:0]   y_reg;     // partial root
   logic [SW-1:0]   s_reg;     // bit position of the current 3-bit group
   logic [PW-1:0]   a_reg;     // multiplicand, shifted left each MUL cycle
   logic [YW-1:0]   m_reg;     // multiplier, consumed LSB first
   logic [PW-1:0]   p_reg;     // product accumulator
   logic [CW-1:0]   cnt_reg;   // MUL cycle counter

   logic [XI-1:0]   x_in;
   logic [PW+1:0]   p3_next;
   logic [BW-1:0]   b_next;
   logic            take_next;
   logic [YW-1:0]   y_dbl_next;

   // Zero-extend the operand to a whole number of 3-bit groups.
   genvar gi;
   generate
      for (gi = 0; gi < XI; gi++) begin : g_xext
         if (gi < XW) begin : g_bit
            assign x_in[gi] = x_bi[gi];
         end else begin : g_pad
            assign x_in[gi] = 1'b0;
         end
      end
   endgenerate

   // Trial subtrahend b = (3*p + 1) << s and the accept decision.
   assign p3_next    = {1'b0, p_reg, 1'b0} + {2'b00, p_reg} + {{(PW+1){1'b0}}, 1'b1};
   assign b_next     = {{(BW-PW-2){1'b0}}, p3_next} << s_reg;
   assign take_next  = ({2'b00, x_reg} >= b_next);
   assign y_dbl_next = y_reg << 1;

   // Control FSM and datapath, registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         x_reg     <= '0;
         y_reg     <= '0;
         s_reg     <= '0;
         a_reg     <= '0;
         m_reg     <= '0;
         p_reg     <= '0;
         cnt_reg   <= '0;
         busy_o    <= 1'b0;
         ready_o   <= 1'b0;
         y_bo      <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  x_reg     <= x_in;
                  y_reg     <= '0;
                  s_reg     <= S_INIT;
                  ready_o   <= 1'b0;
                  busy_o    <= 1'b1;
                  state_reg <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Make room for the next root bit and set up y'*(y'+1).
               y_reg     <= y_dbl_next;
               a_reg     <= {{YW{1'b0}}, y_dbl_next};
               m_reg     <= y_dbl_next | {{(YW-1){1'b0}}, 1'b1};
               p_reg     <= '0;
               cnt_reg   <= '0;
               state_reg <= ST_MUL;
            end
            ST_MUL: begin
               // One multiplier bit per cycle, LSB first.
               if (m_reg[0]) begin
                  p_reg <= p_reg + a_reg;
               end
               a_reg   <= a_reg << 1;
               m_reg   <= m_reg >> 1;
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == MUL_LAST) begin
                  state_reg <= ST_CMP;
               end
            end
            ST_CMP: begin
               // Keep the new root bit only if the remainder can absorb it.
               if (take_next) begin
                  x_reg    <= x_reg - b_next[XI-1:0];
                  y_reg[0] <= 1'b1;
               end
               if (s_reg == '0) begin
                  state_reg <= ST_FIN;
               end else begin
                  s_reg     <= s_reg - SW'(3);
                  state_reg <= ST_SHIFT;
               end
            end
            ST_FIN: begin
               // Publish the finished root and hand back the handshake.
               y_bo      <= y_reg;
               ready_o   <= 1'b1;
               busy_o    <= 1'b0;
               state_reg <= ST_DONE;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_o    <= 1'b0;
               ready_o   <= 1'b0;
            end
         endcase
      end
   end

`ifdef CUB_REM_EN
   // Remainder register: whatever is left of the operand once all groups are done.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_bo <= '0;
      end else if (state_reg == ST_FIN) begin
         rem_bo <= x_reg[XW-1:0];
      end
   end
`endif

endmodule
